// File: rtl/apple_bus_sampler.sv
// Apple II bus sampler: latches address/control/data at programmable phase counts after Phi1 edges.
// Optional bitwise 2-of-3 data vote around DATA_COUNT is enabled by defining A2BUS_DATA_VOTE_EN.
module apple_bus_sampler #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int COUNT_W       = 6,
  parameter int ADDR_COUNT    = 18,
  parameter int DATA_COUNT    = 15,
  parameter int M2B0_COUNT    = 12,
  parameter int CAPTURE_READS = 0
) (
  input  logic                  clk_logic_i,
  input  logic                  system_reset_n_i,
  input  logic                  phi1_i,
  input  logic                  phi1_posedge_i,
  input  logic                  phi1_negedge_i,
  input  logic [ADDR_WIDTH-1:0] a2_a_i,
  input  logic [DATA_WIDTH-1:0] a2_d_i,
  input  logic                  a2_rw_n_i,
  input  logic                  a2_m2sel_n_i,
  input  logic                  a2_m2b0_i,
  input  logic                  miss_clear_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_n_o,
  output logic                  m2sel_n_o,
  output logic                  m2b0_o,
  output logic                  addr_strobe_o,
  output logic                  data_in_strobe_o,
  output logic                  sleep_o,
  output logic                  sample_miss_o,
  output logic [15:0]           bus_cycle_count_o
);

  localparam int CNT_SAT = (1 << COUNT_W) - 1;
  localparam logic [COUNT_W-1:0] ADDR_PT = COUNT_W'(ADDR_COUNT);
  localparam logic [COUNT_W-1:0] DATA_PT = COUNT_W'(DATA_COUNT);
  localparam logic [COUNT_W-1:0] M2B0_PT = COUNT_W'(M2B0_COUNT);

  // Sample points must be reachable before the counter saturates into sleep.
  generate
    if (ADDR_COUNT >= CNT_SAT - 1 || DATA_COUNT >= CNT_SAT - 1 || M2B0_COUNT >= CNT_SAT - 1) begin : g_bad_count
      $error("apple_bus_sampler: sample count too large for COUNT_W");
    end
`ifdef A2BUS_DATA_VOTE_EN
    if (DATA_COUNT + 1 >= CNT_SAT - 1 || DATA_COUNT < 1) begin : g_bad_vote
      $error("apple_bus_sampler: DATA_COUNT leaves no room for the vote window");
    end
`endif
  endgenerate

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [COUNT_W-1:0]    cnt_p0;
  logic                  addr_vld_p0;
  logic                  m2b0_vld_p0;
  logic                  data_vld_p0;
  logic [DATA_WIDTH-1:0] data_val_p0;
  logic                  data_wr_ok_p0;
  logic                  addr_pend;
  logic                  data_pend;
  logic                  miss_new;

  // Stage p0: compare the live phase count against each sample point
  assign addr_vld_p0   = phi1_i && (cnt_p0 == ADDR_PT);
  assign m2b0_vld_p0   = phi1_i && (cnt_p0 == M2B0_PT);
  assign data_wr_ok_p0 = !rw_n_o || (CAPTURE_READS != 0);

`ifdef A2BUS_DATA_VOTE_EN
  localparam logic [COUNT_W-1:0] VOTE0_PT = COUNT_W'(DATA_COUNT - 1);
  localparam logic [COUNT_W-1:0] VOTE2_PT = COUNT_W'(DATA_COUNT + 1);

  function automatic logic [DATA_WIDTH-1:0] maj3(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b,
                                                 input logic [DATA_WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [DATA_WIDTH-1:0] vote0_p0;
  logic [DATA_WIDTH-1:0] vote1_p0;

  // Vote taps are pure data: they are always rewritten before the vote point is reached.
  always_ff @(posedge clk_logic_i) begin
    if (!phi1_i && (cnt_p0 == VOTE0_PT)) vote0_p0 <= a2_d_i;
    if (!phi1_i && (cnt_p0 == DATA_PT))  vote1_p0 <= a2_d_i;
  end

  assign data_vld_p0 = !phi1_i && (cnt_p0 == VOTE2_PT);
  assign data_val_p0 = maj3(vote0_p0, vote1_p0, a2_d_i);
`else
  assign data_vld_p0 = !phi1_i && (cnt_p0 == DATA_PT);
  assign data_val_p0 = a2_d_i;
`endif

  // An edge that finds its phase's sample still outstanding is a miss, unless the sample lands now.
  assign miss_new = (phi1_posedge_i && addr_pend && !addr_vld_p0) ||
                    (phi1_negedge_i && data_pend && !data_vld_p0);

  assign sleep_o = (cnt_p0 == '1);

  // Stage p1: held samples, strobes and bus status
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      cnt_p0            <= '1;
      addr_o            <= '0;
      data_o            <= '0;
      rw_n_o            <= 1'b1;
      m2sel_n_o         <= 1'b1;
      m2b0_o            <= 1'b0;
      addr_strobe_o     <= 1'b0;
      data_in_strobe_o  <= 1'b0;
      addr_pend         <= 1'b0;
      data_pend         <= 1'b0;
      sample_miss_o     <= 1'b0;
      bus_cycle_count_o <= 16'd0;
    end else begin
      if (phi1_posedge_i || phi1_negedge_i) cnt_p0 <= '0;
      else                                  cnt_p0 <= sat_inc(cnt_p0);

      if (addr_vld_p0) begin
        addr_o    <= a2_a_i;
        rw_n_o    <= a2_rw_n_i;
        m2sel_n_o <= a2_m2sel_n_i;
      end
      if (m2b0_vld_p0) m2b0_o <= a2_m2b0_i;
      if (data_vld_p0 && data_wr_ok_p0) data_o <= data_val_p0;

      addr_strobe_o    <= addr_vld_p0;
      data_in_strobe_o <= data_vld_p0;

      if (phi1_posedge_i)   addr_pend <= 1'b1;
      else if (addr_vld_p0) addr_pend <= 1'b0;
      if (phi1_negedge_i)   data_pend <= 1'b1;
      else if (data_vld_p0) data_pend <= 1'b0;

      if (miss_new)          sample_miss_o <= 1'b1;
      else if (miss_clear_i) sample_miss_o <= 1'b0;

      if (phi1_posedge_i) bus_cycle_count_o <= bus_cycle_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_apple_bus_sampler.sv
// Directed bench for apple_bus_sampler: one task per scenario, two instances (writes-only and capture-reads).
module tb_apple_bus_sampler;

`ifdef A2BUS_DATA_VOTE_EN
  localparam int DLAT = 18;
`else
  localparam int DLAT = 17;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phi1, phi1_pos, phi1_neg;
  logic [15:0] a;
  logic [7:0]  d;
  logic        rw_n, m2sel_n, m2b0, miss_clr;

  logic [15:0] addr_o, cnt_o, addr_o_r, cnt_o_r;
  logic [7:0]  data_o, data_o_r;
  logic        rw_o, m2sel_o, m2b0_o, astb, dstb, sleep, miss;
  logic        rw_o_r, m2sel_o_r, m2b0_o_r, astb_r, dstb_r, sleep_r, miss_r;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int addr_at, data_at, astb_n;
  logic [15:0] addr_val;
  logic [7:0]  data_val, data_val_r;
  logic        rw_val, m2sel_val;

  always #5 clk = ~clk;

  apple_bus_sampler #(.CAPTURE_READS(0)) dut (
    .clk_logic_i(clk), .system_reset_n_i(rst_n), .phi1_i(phi1),
    .phi1_posedge_i(phi1_pos), .phi1_negedge_i(phi1_neg),
    .a2_a_i(a), .a2_d_i(d), .a2_rw_n_i(rw_n), .a2_m2sel_n_i(m2sel_n), .a2_m2b0_i(m2b0),
    .miss_clear_i(miss_clr),
    .addr_o(addr_o), .data_o(data_o), .rw_n_o(rw_o), .m2sel_n_o(m2sel_o), .m2b0_o(m2b0_o),
    .addr_strobe_o(astb), .data_in_strobe_o(dstb), .sleep_o(sleep),
    .sample_miss_o(miss), .bus_cycle_count_o(cnt_o)
  );

  apple_bus_sampler #(.CAPTURE_READS(1)) dut_rd (
    .clk_logic_i(clk), .system_reset_n_i(rst_n), .phi1_i(phi1),
    .phi1_posedge_i(phi1_pos), .phi1_negedge_i(phi1_neg),
    .a2_a_i(a), .a2_d_i(d), .a2_rw_n_i(rw_n), .a2_m2sel_n_i(m2sel_n), .a2_m2b0_i(m2b0),
    .miss_clear_i(miss_clr),
    .addr_o(addr_o_r), .data_o(data_o_r), .rw_n_o(rw_o_r), .m2sel_n_o(m2sel_o_r), .m2b0_o(m2b0_o_r),
    .addr_strobe_o(astb_r), .data_in_strobe_o(dstb_r), .sleep_o(sleep_r),
    .sample_miss_o(miss_r), .bus_cycle_count_o(cnt_o_r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pos();
    phi1 = 1'b1; phi1_pos = 1'b1;
    tick();
    phi1_pos = 1'b0;
    exp_count = (exp_count + 1) & 16'hFFFF;
  endtask

  // One full bus cycle; records strobe arrival (clocks after the edge pulse) and held values there.
  task automatic bus_cycle(input logic [15:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic rw, input logic m2s, input logic mb,
                           input int len1, input int len0, input logic clr);
    addr_at = -1; data_at = -1; astb_n = 0;
    a = addr; rw_n = rw; m2sel_n = m2s; m2b0 = mb; d = d1; miss_clr = clr;
    pulse_pos();
    miss_clr = 1'b0;
    for (int k = 1; k < len1; k++) begin
      if (astb) begin
        astb_n++;
        if (addr_at < 0) begin addr_at = k; addr_val = addr_o; rw_val = rw_o; m2sel_val = m2sel_o; end
      end
      tick();
    end
    phi1 = 1'b0; phi1_neg = 1'b1;
    tick();
    phi1_neg = 1'b0;
    for (int k = 1; k < len0; k++) begin
      if (dstb && data_at < 0) begin data_at = k; data_val = data_o; data_val_r = data_o_r; end
      d = (k - 1 == 14) ? d0 : (k - 1 == 16) ? d2 : d1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phi1 = 1'b0; phi1_pos = 1'b0; phi1_neg = 1'b0;
    a = 16'h0; d = 8'h0; rw_n = 1'b1; m2sel_n = 1'b1; m2b0 = 1'b0; miss_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({addr_o, data_o, rw_o, m2sel_o, m2b0_o} !== {16'h0, 8'h0, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_held: got %h %h %b%b%b want 0000 00 110", addr_o, data_o, rw_o, m2sel_o, m2b0_o);
    end
    checks++;
    if ({astb, dstb, miss} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got strobes/miss %b%b%b want 000", astb, dstb, miss);
    end
    checks++;
    if (sleep !== 1'b1) begin errors++; $display("FAIL reset_sleep: got %b want 1", sleep); end
    checks++;
    if (cnt_o !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0000", cnt_o); end
  endtask

  task automatic test_write();
    bus_cycle(16'hC0A5, 8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1, 26, 26, 1'b0);
    checks++;
    if (addr_at !== 20) begin errors++; $display("FAIL write_addr_latency: got %0d want 20", addr_at); end
    checks++;
    if (astb_n !== 1) begin errors++; $display("FAIL write_addr_strobe_width: got %0d want 1", astb_n); end
    checks++;
    if ({addr_val, rw_val, m2sel_val} !== {16'hC0A5, 1'b0, 1'b0}) begin
      errors++; $display("FAIL write_addr: got %h rw=%b m2sel=%b want C0A5 rw=0 m2sel=0", addr_val, rw_val, m2sel_val);
    end
    checks++;
    if (data_at !== DLAT) begin errors++; $display("FAIL write_data_latency: got %0d want %0d", data_at, DLAT); end
    checks++;
    if (data_val !== 8'h3C) begin errors++; $display("FAIL write_data: got %h want 3C", data_val); end
    checks++;
    if (m2b0_o !== 1'b1) begin errors++; $display("FAIL write_m2b0: got %b want 1", m2b0_o); end
    checks++;
    if ({sleep, miss} !== 2'b00) begin errors++; $display("FAIL write_status: got sleep/miss %b%b want 00", sleep, miss); end
  endtask

  task automatic test_read();
    bus_cycle(16'h1234, 8'h77, 8'h77, 8'h77, 1'b1, 1'b1, 1'b0, 26, 26, 1'b0);
    checks++;
    if (data_at !== DLAT) begin errors++; $display("FAIL read_strobe: got %0d want %0d", data_at, DLAT); end
    checks++;
    if (data_val !== 8'h3C) begin errors++; $display("FAIL read_writes_only: got %h want 3C", data_val); end
    checks++;
    if (data_val_r !== 8'h77) begin errors++; $display("FAIL read_capture_reads: got %h want 77", data_val_r); end
    checks++;
    if ({addr_val, rw_val} !== {16'h1234, 1'b1}) begin
      errors++; $display("FAIL read_addr: got %h rw=%b want 1234 rw=1", addr_val, rw_val);
    end
  endtask

  task automatic test_vote();
    bus_cycle(16'h0400, 8'h55, 8'hFF, 8'h55, 1'b0, 1'b1, 1'b0, 26, 26, 1'b0);
    checks++;
    if (data_at !== DLAT) begin errors++; $display("FAIL vote_latency: got %0d want %0d", data_at, DLAT); end
    checks++;
`ifdef A2BUS_DATA_VOTE_EN
    if (data_val !== 8'h55) begin errors++; $display("FAIL vote_data: got %h want 55", data_val); end
`else
    if (data_val !== 8'hFF) begin errors++; $display("FAIL single_sample_data: got %h want FF", data_val); end
`endif
  endtask

  task automatic test_miss();
    bus_cycle(16'h0001, 8'h11, 8'h11, 8'h11, 1'b0, 1'b1, 1'b0, 10, 26, 1'b0);
    checks++;
    if (addr_at !== -1) begin errors++; $display("FAIL miss_no_addr_strobe: got %0d want none", addr_at); end
    checks++;
    if (miss !== 1'b0) begin errors++; $display("FAIL miss_early: got %b want 0", miss); end
    bus_cycle(16'h0002, 8'h22, 8'h22, 8'h22, 1'b0, 1'b1, 1'b0, 26, 26, 1'b0);
    checks++;
    if (miss !== 1'b1) begin errors++; $display("FAIL miss_set: got %b want 1", miss); end
    bus_cycle(16'h0003, 8'h33, 8'h33, 8'h33, 1'b0, 1'b1, 1'b0, 26, 26, 1'b0);
    checks++;
    if (miss !== 1'b1) begin errors++; $display("FAIL miss_sticky: got %b want 1", miss); end
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    checks++;
    if (miss !== 1'b0) begin errors++; $display("FAIL miss_clear: got %b want 0", miss); end
    bus_cycle(16'h0004, 8'h44, 8'h44, 8'h44, 1'b0, 1'b1, 1'b0, 10, 26, 1'b0);
    bus_cycle(16'h0005, 8'h55, 8'h55, 8'h55, 1'b0, 1'b1, 1'b0, 26, 26, 1'b1);
    checks++;
    if (miss !== 1'b1) begin errors++; $display("FAIL miss_clear_vs_new: got %b want 1", miss); end
  endtask

  task automatic test_sleep_wrap();
    checks++;
    if (cnt_o !== 16'(exp_count)) begin errors++; $display("FAIL count_track: got %h want %h", cnt_o, 16'(exp_count)); end
    while (exp_count != 16'hFFFF) pulse_pos();
    repeat (62) tick();
    checks++;
    if ({sleep, cnt_o} !== {1'b0, 16'hFFFF}) begin
      errors++; $display("FAIL sleep_before: got sleep=%b count=%h want 0 FFFF", sleep, cnt_o);
    end
    tick();
    checks++;
    if (sleep !== 1'b1) begin errors++; $display("FAIL sleep_assert: got %b want 1", sleep); end
    pulse_pos();
    checks++;
    if ({sleep, cnt_o} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL wake_wrap: got sleep=%b count=%h want 0 0000", sleep, cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    a = 16'hBEEF; rw_n = 1'b0;
    pulse_pos();
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({addr_o, data_o, rw_o, m2sel_o, m2b0_o} !== {16'h0, 8'h0, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midreset_held: got %h %h %b%b%b want 0000 00 110", addr_o, data_o, rw_o, m2sel_o, m2b0_o);
    end
    checks++;
    if ({astb, dstb, miss, sleep, cnt_o} !== {4'b0001, 16'h0}) begin
      errors++; $display("FAIL midreset_status: got %b%b%b%b %h want 0001 0000", astb, dstb, miss, sleep, cnt_o);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (astb || dstb || astb_r || dstb_r) seen++;
    end
    checks++;
    if ({seen, addr_o} !== {32'd0, 16'h0}) begin
      errors++; $display("FAIL post_reset_quiet: got strobes=%0d addr=%h want 0 0000", seen, addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_vote();
    test_miss();
    test_sleep_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
